// File: rtl/alu_issue_pkg.sv
// Shared definitions for the alu_issue block: widths, instruction field positions, FSM states.
package alu_issue_pkg;

    localparam int unsigned DataWidth    = 16;
    localparam int unsigned OpWidth      = 2;
    localparam int unsigned RegCount     = 4;
    localparam int unsigned RegAddrWidth = 2;
    localparam int unsigned InstrWidth   = 16;
    localparam int unsigned Imm7Width    = 7;

    // Instruction field positions
    localparam int unsigned OpMsb     = 15;
    localparam int unsigned OpLsb     = 14;
    localparam int unsigned RdMsb     = 13;
    localparam int unsigned RdLsb     = 12;
    localparam int unsigned Rs0Msb    = 11;
    localparam int unsigned Rs0Lsb    = 10;
    localparam int unsigned Rs1Msb    = 9;
    localparam int unsigned Rs1Lsb    = 8;
    localparam int unsigned ImmSelBit = 7;
    localparam int unsigned Imm7Msb   = 6;
    localparam int unsigned Imm7Lsb   = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StExec  = 2'd2,
        StWb    = 2'd3
    } state_e;

    typedef struct packed {
        logic [OpWidth-1:0]      op;
        logic [RegAddrWidth-1:0] rd;
        logic [RegAddrWidth-1:0] rs0;
        logic [RegAddrWidth-1:0] rs1;
        logic                    imm_sel;
        logic [Imm7Width-1:0]    imm7;
    } instr_t;

    function automatic instr_t decode_instr(input logic [InstrWidth-1:0] raw);
        instr_t d;
        d.op      = raw[OpMsb:OpLsb];
        d.rd      = raw[RdMsb:RdLsb];
        d.rs0     = raw[Rs0Msb:Rs0Lsb];
        d.rs1     = raw[Rs1Msb:Rs1Lsb];
        d.imm_sel = raw[ImmSelBit];
        d.imm7    = raw[Imm7Msb:Imm7Lsb];
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 4 x 16-bit register file: two operand read ports, one debug read port,
// writeback and direct-load write ports (writeback wins on the same register).
module alu_issue_regfile
    import alu_issue_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RegAddrWidth-1:0] rd_addr0,
    output logic [DataWidth-1:0]    rd_data0,
    input  logic [RegAddrWidth-1:0] rd_addr1,
    output logic [DataWidth-1:0]    rd_data1,
    input  logic [RegAddrWidth-1:0] dbg_addr,
    output logic [DataWidth-1:0]    dbg_data,
    input  logic                    wb_en,
    input  logic [RegAddrWidth-1:0] wb_addr,
    input  logic [DataWidth-1:0]    wb_data,
    input  logic                    ld_en,
    input  logic [RegAddrWidth-1:0] ld_addr,
    input  logic [DataWidth-1:0]    ld_data
);

    logic [DataWidth-1:0] regs_q [RegCount];
    logic [DataWidth-1:0] regs_d [RegCount];

    always_comb begin
        for (int i = 0; i < RegCount; i++) begin
            regs_d[i] = regs_q[i];
            if (wb_en && (wb_addr == RegAddrWidth'(i))) begin
                regs_d[i] = wb_data;
            end else if (ld_en && (ld_addr == RegAddrWidth'(i))) begin
                regs_d[i] = ld_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RegCount; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RegCount; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rd_data0 = regs_q[rd_addr0];
    assign rd_data1 = regs_q[rd_addr1];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Single-issue sequencer for an external registered ALU: IDLE -> ISSUE -> EXEC -> WB.
// Optional macro ALU_ISSUE_IMM_EN selects a zero-extended imm7 as the second operand.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [InstrWidth-1:0]   instr,
    input  logic                    ld_en,
    input  logic [RegAddrWidth-1:0] ld_addr,
    input  logic [DataWidth-1:0]    ld_data,
    output logic [OpWidth-1:0]      alu_cnt,
    output logic [DataWidth-1:0]    alu_in0,
    output logic [DataWidth-1:0]    alu_in1,
    input  logic [DataWidth-1:0]    alu_out,
    output logic                    wb_valid,
    output logic [DataWidth-1:0]    wb_data,
    input  logic [RegAddrWidth-1:0] dbg_addr,
    output logic [DataWidth-1:0]    dbg_data
);

    state_e               state_q, state_d;
    instr_t               instr_q;
    logic [OpWidth-1:0]   alu_cnt_q;
    logic [DataWidth-1:0] alu_in0_q, alu_in1_q;
    logic [DataWidth-1:0] rs0_data, rs1_data, operand1;
    logic                 accept;

    // Gated by rst so the handshake is dead while reset is held.
    assign instr_ready = (state_q == StIdle) && rst;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifdef ALU_ISSUE_IMM_EN
    assign operand1 = instr_q.imm_sel ? {{(DataWidth - Imm7Width){1'b0}}, instr_q.imm7}
                                      : rs1_data;
`else
    logic unused_imm;
    assign unused_imm = ^{instr_q.imm_sel, instr_q.imm7};
    assign operand1   = rs1_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            instr_q   <= '0;
            alu_cnt_q <= '0;
            alu_in0_q <= '0;
            alu_in1_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q <= decode_instr(instr);
            end
            // Operands are launched only on ISSUE->EXEC and held until the next one.
            if (state_q == StIssue) begin
                alu_cnt_q <= instr_q.op;
                alu_in0_q <= rs0_data;
                alu_in1_q <= operand1;
            end
        end
    end

    assign alu_cnt  = alu_cnt_q;
    assign alu_in0  = alu_in0_q;
    assign alu_in1  = alu_in1_q;
    assign wb_valid = (state_q == StWb);
    assign wb_data  = alu_out;

    alu_issue_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_addr0 (instr_q.rs0),
        .rd_data0 (rs0_data),
        .rd_addr1 (instr_q.rs1),
        .rd_data1 (rs1_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wb_en    (wb_valid),
        .wb_addr  (instr_q.rd),
        .wb_data  (alu_out),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: table of instructions with expected operands/results, a result
// scoreboard, a behavioural registered ALU, and sequences for load conflicts and reset.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        ld_en;
    logic [1:0]  ld_addr;
    logic [15:0] ld_data;
    logic [1:0]  alu_cnt;
    logic [15:0] alu_in0, alu_in1, alu_out;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [1:0]  dbg_addr;
    logic [15:0] dbg_data;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] sb_q [$];
    logic [1:0]  prev_cnt = '0;
    logic [15:0] prev_in0 = '0;
    logic [15:0] prev_in1 = '0;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  rd;
        logic [1:0]  rs0;
        logic [1:0]  rs1;
        logic        imm_sel;
        logic [6:0]  imm7;
        logic [15:0] exp_in0;
        logic [15:0] exp_in1;
        logic [15:0] exp_res;
    } vec_t;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_cnt     (alu_cnt),
        .alu_in0     (alu_in0),
        .alu_in1     (alu_in1),
        .alu_out     (alu_out),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    function automatic logic [15:0] alu_f(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // External registered ALU
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) alu_out <= '0;
        else      alu_out <= alu_f(alu_cnt, alu_in0, alu_in1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reg(input logic [1:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), dbg_data, exp);
    endtask

    task automatic load(input logic [1:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Runs one instruction from IDLE (called at a negedge); instr_valid stays high and
    // instr is scrambled after acceptance to show later offers are ignored.
    task automatic run_instr(input vec_t v, input logic ld_wb, input logic [1:0] la,
                             input logic [15:0] ldv);
        instr_valid = 1'b1;
        instr = {v.op, v.rd, v.rs0, v.rs1, v.imm_sel, v.imm7};
        #1;
        chk("ready_idle", instr_ready, 1'b1);
        chk("wb_idle", wb_valid, 1'b0);
        sb_q.push_back(v.exp_res);
        @(posedge clk); @(negedge clk);
        instr = 16'($urandom);
        #1;
        chk("ready_issue", instr_ready, 1'b0);
        chk("hold_cnt", alu_cnt, prev_cnt);
        chk("hold_in0", alu_in0, prev_in0);
        chk("hold_in1", alu_in1, prev_in1);
        @(posedge clk); @(negedge clk);
        instr = 16'($urandom);
        #1;
        chk("ready_exec", instr_ready, 1'b0);
        chk("exec_cnt", alu_cnt, v.op);
        chk("exec_in0", alu_in0, v.exp_in0);
        chk("exec_in1", alu_in1, v.exp_in1);
        @(posedge clk); @(negedge clk);
        instr = 16'($urandom);
        #1;
        chk("ready_wb", instr_ready, 1'b0);
        chk("wb_valid", wb_valid, 1'b1);
        chk("wb_hold_in0", alu_in0, v.exp_in0);
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            chk("wb_data", wb_data, sb_q.pop_front());
        end
        if (ld_wb) begin
            ld_en   = 1'b1;
            ld_addr = la;
            ld_data = ldv;
        end
        @(posedge clk); @(negedge clk);
        ld_en    = 1'b0;
        prev_cnt = v.op;
        prev_in0 = v.exp_in0;
        prev_in1 = v.exp_in1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        vec_t v;
        logic [15:0] imm_exp;

        vecs[0] = '{2'b01, 2'd3, 2'd1, 2'd2, 1'b0, 7'h00, 16'h7777, 16'h5555, 16'h2222};
        vecs[1] = '{2'b00, 2'd0, 2'd3, 2'd1, 1'b0, 7'h00, 16'h2222, 16'h7777, 16'h9999};
        vecs[2] = '{2'b10, 2'd1, 2'd0, 2'd2, 1'b0, 7'h00, 16'h9999, 16'h5555, 16'h1111};
        vecs[3] = '{2'b11, 2'd2, 2'd1, 2'd3, 1'b0, 7'h00, 16'h1111, 16'h2222, 16'h3333};

        instr_valid = 1'b0;
        instr       = '0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        dbg_addr    = '0;

        #2 rst = 1'b0;
        #1;
        chk("rst_ready", instr_ready, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_alu_cnt", alu_cnt, 2'b00);
        chk("rst_alu_in0", alu_in0, 16'h0);
        chk("rst_alu_in1", alu_in1, 16'h0);
        for (int i = 0; i < 4; i++) chk_reg(2'(i), 16'h0);
        @(negedge clk);
        rst = 1'b1;

        load(2'd1, 16'h7777);
        load(2'd2, 16'h5555);

        // Back-to-back issue of all four ops
        for (int i = 0; i < 4; i++) run_instr(vecs[i], 1'b0, 2'd0, 16'h0);
        instr_valid = 1'b0;
        chk_reg(2'd0, 16'h9999);
        chk_reg(2'd1, 16'h1111);
        chk_reg(2'd2, 16'h3333);
        chk_reg(2'd3, 16'h2222);

        // Idle with no offer stays idle
        @(posedge clk); @(negedge clk);
        #1;
        chk("idle_ready", instr_ready, 1'b1);
        chk("idle_wb", wb_valid, 1'b0);

        // Writeback beats a load to the same register
        v = '{2'b00, 2'd3, 2'd0, 2'd1, 1'b0, 7'h00, 16'h9999, 16'h1111, 16'haaaa};
        run_instr(v, 1'b1, 2'd3, 16'h1234);
        instr_valid = 1'b0;
        chk_reg(2'd3, 16'haaaa);

        // Load to a different register on the writeback edge lands too
        v = '{2'b11, 2'd1, 2'd2, 2'd3, 1'b0, 7'h00, 16'h3333, 16'haaaa, 16'h9999};
        run_instr(v, 1'b1, 2'd0, 16'h1234);
        instr_valid = 1'b0;
        chk_reg(2'd0, 16'h1234);
        chk_reg(2'd1, 16'h9999);

        // Immediate operand select
        load(2'd2, 16'hffff);
`ifdef ALU_ISSUE_IMM_EN
        imm_exp = 16'h007f;
`else
        imm_exp = 16'hffff;
`endif
        v = '{2'b10, 2'd0, 2'd2, 2'd2, 1'b1, 7'h7f, 16'hffff, imm_exp, imm_exp};
        run_instr(v, 1'b0, 2'd0, 16'h0);
        instr_valid = 1'b0;
        chk_reg(2'd0, imm_exp);

        // Reset asserted mid-EXEC aborts the instruction
        instr_valid = 1'b1;
        instr = {2'b00, 2'd3, 2'd2, 2'd2, 1'b0, 7'h00};
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        chk("pre_rst_exec_in0", alu_in0, 16'hffff);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", instr_ready, 1'b0);
        chk("mid_rst_wb_valid", wb_valid, 1'b0);
        chk("mid_rst_alu_cnt", alu_cnt, 2'b00);
        chk("mid_rst_alu_in0", alu_in0, 16'h0);
        chk("mid_rst_alu_in1", alu_in1, 16'h0);
        for (int i = 0; i < 4; i++) chk_reg(2'(i), 16'h0);
        @(posedge clk); @(negedge clk);
        #1;
        chk("rst_hold_wb_valid", wb_valid, 1'b0);
        rst      = 1'b1;
        prev_cnt = '0;
        prev_in0 = '0;
        prev_in1 = '0;

        // First edge after reset release accepts
        load(2'd1, 16'h00f0);
        v = '{2'b11, 2'd2, 2'd1, 2'd3, 1'b0, 7'h00, 16'h00f0, 16'h0000, 16'h00f0};
        run_instr(v, 1'b0, 2'd0, 16'h0);
        instr_valid = 1'b0;
        chk_reg(2'd2, 16'h00f0);
        chk_reg(2'd3, 16'h0000);

        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
